// File: rtl/tt_pkg.sv
// Shared types and helpers for the per-turn countdown timer.
package tt_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_FROZEN  = 2'd3
  } tt_state_e;

  // Splits a 0..99 seconds value into {tens, ones} BCD digits.
  function automatic logic [2*BCD_DIGIT_W-1:0] to_bcd(input int value);
    logic [BCD_DIGIT_W-1:0] ten;
    logic [BCD_DIGIT_W-1:0] one;
    ten = BCD_DIGIT_W'((value / 10) % 10);
    one = BCD_DIGIT_W'(value % 10);
    return {ten, one};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down-counter with load, saturating decrement and zero/last flags.
module bcd_down_counter
  import tt_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   dec_i,
  input  logic [BCD_DIGIT_W-1:0] load_ten_i,
  input  logic [BCD_DIGIT_W-1:0] load_one_i,
  output logic [BCD_DIGIT_W-1:0] ten_o,
  output logic [BCD_DIGIT_W-1:0] one_o,
  output logic                   zero_o,
  output logic                   last_o
);

  logic [BCD_DIGIT_W-1:0] ten_q, ten_d;
  logic [BCD_DIGIT_W-1:0] one_q, one_d;

  // Load wins over decrement; decrement borrows from tens and never wraps below 00.
  always_comb begin
    ten_d = ten_q;
    one_d = one_q;
    if (load_i) begin
      ten_d = load_ten_i;
      one_d = load_one_i;
    end else if (dec_i) begin
      if (one_q != 4'd0) begin
        one_d = one_q - 4'd1;
      end else if (ten_q != 4'd0) begin
        ten_d = ten_q - 4'd1;
        one_d = 4'd9;
      end else begin
        ten_d = ten_q;
        one_d = one_q;
      end
    end else begin
      ten_d = ten_q;
      one_d = one_q;
    end
  end

  // Digit registers; reset presents the load value.
  always_ff @(posedge clock) begin
    if (reset) begin
      ten_q <= load_ten_i;
      one_q <= load_one_i;
    end else begin
      ten_q <= ten_d;
      one_q <= one_d;
    end
  end

  assign ten_o  = ten_q;
  assign one_o  = one_q;
  assign zero_o = (ten_q == 4'd0) && (one_q == 4'd0);
  assign last_o = (ten_q == 4'd0) && (one_q == 4'd1);

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer with BCD seconds display and one-cycle timeout pulse.
// Optional low-time warning output enabled by defining TURN_TIMER_WARN_EN.
module turn_timer
  import tt_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int TURN_SECONDS  = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   turn_done,
  input  logic                   game_over,
  output logic [BCD_DIGIT_W-1:0] time_left_ten,
  output logic [BCD_DIGIT_W-1:0] time_left_one,
  output logic                   timeout,
  output logic                   running
`ifdef TURN_TIMER_WARN_EN
  ,
  output logic                   warn
`endif
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] TICK_MAX = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [2*BCD_DIGIT_W-1:0] RELOAD = to_bcd(TURN_SECONDS);

  tt_state_e           state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                timeout_q, timeout_d;
  logic                running_q, running_d;
  logic                load_s, dec_s, tick_s, zero_s, last_s;
  logic [BCD_DIGIT_W-1:0] ten_s, one_s;

  assign tick_s = (presc_q == TICK_MAX);

  bcd_down_counter u_digits (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load_s),
    .dec_i      (dec_s),
    .load_ten_i (RELOAD[2*BCD_DIGIT_W-1:BCD_DIGIT_W]),
    .load_one_i (RELOAD[BCD_DIGIT_W-1:0]),
    .ten_o      (ten_s),
    .one_o      (one_s),
    .zero_o     (zero_s),
    .last_o     (last_s)
  );

  // Next-state and registered-output decode; game_over > start low > turn_done > tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    load_s  = 1'b0;
    dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_d = {PRESC_W{1'b0}};
        if (start) begin
          state_d = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_FROZEN;
        end else if (!start) begin
          state_d = ST_IDLE;
          load_s  = 1'b1;
          presc_d = {PRESC_W{1'b0}};
        end else if (turn_done) begin
          load_s  = 1'b1;
          presc_d = {PRESC_W{1'b0}};
        end else if (tick_s) begin
          dec_s   = 1'b1;
          presc_d = {PRESC_W{1'b0}};
          if (last_s || zero_s) begin
            state_d = ST_EXPIRED;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      ST_EXPIRED: begin
        presc_d = {PRESC_W{1'b0}};
        if (game_over) begin
          state_d = ST_FROZEN;
        end else if (!start) begin
          state_d = ST_IDLE;
          load_s  = 1'b1;
        end else begin
          state_d = ST_RUN;
          load_s  = 1'b1;
        end
      end
      ST_FROZEN: begin
        state_d = ST_FROZEN;
      end
      default: begin
        state_d = ST_IDLE;
        load_s  = 1'b1;
        presc_d = {PRESC_W{1'b0}};
      end
    endcase
    running_d = (state_d == ST_RUN);
    timeout_d = (state_d == ST_EXPIRED);
  end

  // Control state and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= {PRESC_W{1'b0}};
      timeout_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      running_q <= running_d;
    end
  end

  assign time_left_ten = ten_s;
  assign time_left_one = one_s;
  assign timeout       = timeout_q;
  assign running       = running_q;

`ifdef TURN_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Warn predicts the digits after this edge: a pending decrement lowers the threshold by one.
  always_comb begin
    warn_d = 1'b0;
    if ((state_d == ST_RUN) && !load_s) begin
      if (dec_s) begin
        warn_d = (ten_s == 4'd0) && (one_s <= 4'd4);
      end else begin
        warn_d = (ten_s == 4'd0) && (one_s <= 4'd3);
      end
    end else begin
      warn_d = 1'b0;
    end
  end

  // Warning register.
  always_ff @(posedge clock) begin
    if (reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`endif

endmodule

// File: tb/tb_turn_timer.sv
// Scoreboard bench for turn_timer: a seconds-level reference model predicts each cycle's outputs.
module tb_turn_timer;

  localparam int TPS  = 4;
  localparam int SECS = 12;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_EXP    = 2;
  localparam int M_FROZEN = 3;

  typedef struct {
    logic [3:0] ten;
    logic [3:0] one;
    logic       to;
    logic       run;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       turn_done = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] time_left_ten;
  logic [3:0] time_left_one;
  logic       timeout;
  logic       running;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  int m_mode  = M_IDLE;
  int m_secs  = SECS;
  int m_phase = 0;

  turn_timer #(.TICKS_PER_SEC(TPS), .TURN_SECONDS(SECS)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .turn_done     (turn_done),
    .game_over     (game_over),
    .time_left_ten (time_left_ten),
    .time_left_one (time_left_one),
    .timeout       (timeout),
    .running       (running)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Reference behaviour in whole seconds and tick phase, following the event priorities.
  task automatic model_update(input logic r, input logic s, input logic td, input logic go);
    if (r) begin
      m_mode = M_IDLE; m_secs = SECS; m_phase = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_RUN; m_secs = SECS; m_phase = 0; end
        M_RUN: begin
          if (go) m_mode = M_FROZEN;
          else if (!s) begin m_mode = M_IDLE; m_secs = SECS; m_phase = 0; end
          else if (td) begin m_secs = SECS; m_phase = 0; end
          else if (m_phase == TPS - 1) begin
            m_phase = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) m_mode = M_EXP;
          end else m_phase = m_phase + 1;
        end
        M_EXP: begin
          if (go) m_mode = M_FROZEN;
          else if (!s) begin m_mode = M_IDLE; m_secs = SECS; m_phase = 0; end
          else begin m_mode = M_RUN; m_secs = SECS; m_phase = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic s, input logic td, input logic go);
    exp_t e;
    @(negedge clock);
    reset = r; start = s; turn_done = td; game_over = go;
    @(posedge clock);
    model_update(r, s, td, go);
    e.ten = 4'(m_secs / 10);
    e.one = 4'(m_secs % 10);
    e.to  = (m_mode == M_EXP);
    e.run = (m_mode == M_RUN);
    exp_q.push_back(e);
  endtask

  task automatic run_until(input int ts, input int tp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_mode == M_RUN && m_secs == ts && m_phase == tp) return;
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    total++;
    bad++;
    $display("FAIL run_until: target %0d/%0d not reached within %0d cycles", ts, tp, budget);
  endtask

  // Monitor: compares every cycle's outputs with the oldest prediction.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ten",     time_left_ten, mon_e.ten);
      check("one",     time_left_one, mon_e.one);
      check("timeout", timeout,       mon_e.to);
      check("running", running,       mon_e.run);
    end
  end

  initial begin
    // reset and idle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // start, count down, run out and auto-reload
    repeat (60) step(1'b0, 1'b1, 1'b0, 1'b0);
    // turn_done coinciding with a tick at 0,5
    run_until(5, TPS - 1, 200);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b1, 1'b0, 1'b0);
    // game_over at 0,7 then everything but reset ignored
    run_until(7, 1, 200);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 55; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // game_over on the tick from 0,1: no timeout
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(1, TPS - 1, 200);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
    // reset mid-count at 0,3
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(3, 1, 200);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 149) == 0));
    repeat (2) @(posedge clock);
    #2;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
